// File: rtl/ctrl_pkg.sv
// Purpose : shared control-bundle layout and branch-op encodings for the ID decoders and EX stage.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

    localparam int BUNDLE_W = 22;

    // Bundle field positions
    localparam int B_WE_REG     = 21;
    localparam int B_WE_MEM     = 20;
    localparam int B_NPC_SEL    = 19;
    localparam int B_IMMGEN_MSB = 18;
    localparam int B_IMMGEN_LSB = 16;
    localparam int B_ALUOP_MSB  = 15;
    localparam int B_ALUOP_LSB  = 12;
    localparam int B_BRALU_MSB  = 11;
    localparam int B_BRALU_LSB  = 9;
    localparam int B_ASEL_MSB   = 8;
    localparam int B_ASEL_LSB   = 7;
    localparam int B_BSEL_MSB   = 6;
    localparam int B_BSEL_LSB   = 5;
    localparam int B_WBSEL_MSB  = 4;
    localparam int B_WBSEL_LSB  = 3;
    localparam int B_MEMW_MSB   = 2;
    localparam int B_MEMW_LSB   = 0;

    typedef logic [BUNDLE_W-1:0] sign_t;
    typedef logic [2:0]          bralu_op_t;

    localparam bralu_op_t BR_NONE = 3'b000;
    localparam bralu_op_t BR_EQ   = 3'b001;
    localparam bralu_op_t BR_NE   = 3'b010;
    localparam bralu_op_t BR_LT   = 3'b011;
    localparam bralu_op_t BR_GE   = 3'b100;
    localparam bralu_op_t BR_LTU  = 3'b101;
    localparam bralu_op_t BR_GEU  = 3'b110;
    localparam bralu_op_t BR_RSVD = 3'b111;

    // Operand-A select value meaning "PC" (target = pc + imm)
    localparam logic [1:0] ASEL_PC = 2'b10;

    // Wrong-path kill state: RUN when no beats left to drop, KILL otherwise
    typedef enum logic {ST_RUN = 1'b0, ST_KILL = 1'b1} kill_state_e;

endpackage

// File: rtl/br_cmp.sv
// Purpose : branch condition evaluator; cond = rs1 <op> rs2 for the selected bralu_op.
// Latency : purely combinational.
// Backpressure: none.
// Ports   : bralu_op (3) in, rs1/rs2 (32) in, cond (1) out. BR_NONE and the reserved code give 0.
module br_cmp
    import ctrl_pkg::*;
(
    input  logic [2:0]  bralu_op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        cond
);

    logic w_lt_s;
    logic w_lt_u;

    assign w_lt_s = $signed(rs1) < $signed(rs2);
    assign w_lt_u = rs1 < rs2;

    always_comb begin
        cond = 1'b0;
        case (bralu_op)
            BR_EQ:   cond = (rs1 == rs2);
            BR_NE:   cond = (rs1 != rs2);
            BR_LT:   cond = w_lt_s;
            BR_GE:   cond = ~w_lt_s;
            BR_LTU:  cond = w_lt_u;
            BR_GEU:  cond = ~w_lt_u;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Purpose : EX-stage ID/EX register, branch resolution, one-shot redirect, wrong-path kill, branch stats.
// Latency : accept at edge E, ex_*/redirect visible in cycle E+1 (redirect is combinational from EX reg).
// Backpressure: stall holds the EX register, blocks accept and counter updates; kill counter holds.
// Ports   : clk, rstn (async low); in_valid/in_pc/in_sign/in_rs1/in_rs2/in_imm from ID; stall;
//           ex_valid/ex_sign to later stages; redirect_valid/redirect_pc/misalign to fetch;
//           br_cnt/taken_cnt statistics.
module branch_resolve
    import ctrl_pkg::*;
#(
    parameter int KILL_DEPTH = 2
)(
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    input  logic [31:0]         in_pc,
    input  logic [BUNDLE_W-1:0] in_sign,
    input  logic [31:0]         in_rs1,
    input  logic [31:0]         in_rs2,
    input  logic [31:0]         in_imm,
    input  logic                stall,
    output logic                ex_valid,
    output logic [BUNDLE_W-1:0] ex_sign,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,
    output logic                misalign,
    output logic [31:0]         br_cnt,
    output logic [31:0]         taken_cnt
);

    localparam logic [1:0] KD = KILL_DEPTH[1:0];

    logic        r_ex_valid;
    sign_t       r_ex_sign;
    logic [31:0] r_pc, r_rs1, r_rs2, r_imm;
    logic        r_fired;
    logic        r_first;
    logic [1:0]  r_kcnt;
    kill_state_e r_state;
    logic [31:0] r_br_cnt, r_taken_cnt;

    logic        w_accept;
    logic        w_npc_sel;
    bralu_op_t   w_bralu;
    logic [1:0]  w_asel;
    logic        w_cond;
    logic        w_taken;
    logic [31:0] w_target;
    logic        w_redirect;
    logic [1:0]  w_kcnt_nxt;
    kill_state_e w_state_nxt;
    logic        w_kill_beat;

    assign w_accept  = in_valid & ~stall;
    assign w_npc_sel = r_ex_sign[B_NPC_SEL];
    assign w_bralu   = r_ex_sign[B_BRALU_MSB:B_BRALU_LSB];
    assign w_asel    = r_ex_sign[B_ASEL_MSB:B_ASEL_LSB];

    br_cmp u_cmp (
        .bralu_op (w_bralu),
        .rs1      (r_rs1),
        .rs2      (r_rs2),
        .cond     (w_cond)
    );

    // BR_NONE under npc_sel is an unconditional jump
    assign w_taken    = (w_bralu == BR_NONE) | w_cond;
    assign w_target   = (w_asel == ASEL_PC) ? (r_pc + r_imm) : ((r_rs1 + r_imm) & ~32'h1);
    // fired blocks a second pulse while the same instruction sits in EX under stall
    assign w_redirect = r_ex_valid & w_npc_sel & w_taken & ~r_fired;

    // Kill FSM: state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_RUN;
            r_kcnt  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_kcnt  <= w_kcnt_nxt;
        end
    end

    // Kill FSM: next state. A beat arriving on the redirect edge is already the first killed one.
    always_comb begin
        w_kcnt_nxt = r_kcnt;
        if (w_redirect)
            w_kcnt_nxt = KD - {1'b0, w_accept};
        else if ((r_state == ST_KILL) && w_accept)
            w_kcnt_nxt = r_kcnt - 2'd1;
        w_state_nxt = (w_kcnt_nxt != 2'd0) ? ST_KILL : ST_RUN;
    end

    // Kill FSM: outputs
    always_comb begin
        w_kill_beat = (r_state == ST_KILL) | w_redirect;
    end

    // ID/EX register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ex_valid <= 1'b0;
            r_ex_sign  <= '0;
            r_pc       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_imm      <= '0;
            r_first    <= 1'b0;
            r_fired    <= 1'b0;
        end else begin
            r_first <= w_accept;
            if (w_accept) begin
                r_ex_valid <= ~w_kill_beat;
                r_ex_sign  <= in_sign;
                r_pc       <= in_pc;
                r_rs1      <= in_rs1;
                r_rs2      <= in_rs2;
                r_imm      <= in_imm;
                r_fired    <= 1'b0;
            end else begin
                if (!stall)
                    r_ex_valid <= 1'b0;
                if (w_redirect)
                    r_fired <= 1'b1;
            end
        end
    end

    // Statistics: counted once, at the end of the first EX cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else if (r_first && r_ex_valid && w_npc_sel) begin
            r_br_cnt <= r_br_cnt + 32'd1;
            if (w_taken)
                r_taken_cnt <= r_taken_cnt + 32'd1;
        end
    end

    assign ex_valid       = r_ex_valid;
    assign ex_sign        = r_ex_sign;
    assign redirect_valid = w_redirect;
    assign redirect_pc    = w_target;
    assign misalign       = w_redirect & w_target[1];
    assign br_cnt         = r_br_cnt;
    assign taken_cnt      = r_taken_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [21:0] in_sign;
    logic [31:0] in_rs1, in_rs2, in_imm;
    logic        stall;
    logic        ex_valid;
    logic [21:0] ex_sign;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign;
    logic [31:0] br_cnt, taken_cnt;

    int n_chk = 0;
    int n_err = 0;
    int pulses;

    always #5 clk = ~clk;

    branch_resolve #(.KILL_DEPTH(2)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .in_valid       (in_valid),
        .in_pc          (in_pc),
        .in_sign        (in_sign),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_imm         (in_imm),
        .stall          (stall),
        .ex_valid       (ex_valid),
        .ex_sign        (ex_sign),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign       (misalign),
        .br_cnt         (br_cnt),
        .taken_cnt      (taken_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // npc_sel at [19], bralu_op at [11:9], alu_asel at [8:7]
    function automatic logic [21:0] mk(input logic npc, input logic [2:0] op, input logic [1:0] asel);
        logic [21:0] s;
        s = '0;
        s[19]  = npc;
        s[11:9] = op;
        s[8:7] = asel;
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [21:0] s, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
        in_valid = 1'b1;
        in_sign  = s;
        in_pc    = pc;
        in_rs1   = a;
        in_rs2   = b;
        in_imm   = imm;
        step();
        in_valid = 1'b0;
    endtask

    task automatic nop_beat();
        issue(mk(1'b0, 3'b000, 2'b00), 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; stall = 1'b0;
        in_pc = '0; in_sign = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        #12;
        check("rst_exv",  {31'b0, ex_valid}, 32'd0);
        check("rst_sign", {10'b0, ex_sign}, 32'd0);
        check("rst_rv",   {31'b0, redirect_valid}, 32'd0);
        check("rst_rpc",  redirect_pc, 32'd0);
        check("rst_mis",  {31'b0, misalign}, 32'd0);
        check("rst_br",   br_cnt, 32'd0);
        check("rst_tk",   taken_cnt, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        // 1: beq taken, pc-relative target, two killed beats then a live one
        issue(mk(1'b1, 3'b001, 2'b10), 32'h100, 32'd5, 32'd5, 32'h20);
        check("t1_exv",  {31'b0, ex_valid}, 32'd1);
        check("t1_sign", {10'b0, ex_sign}, {10'b0, mk(1'b1, 3'b001, 2'b10)});
        check("t1_rv",   {31'b0, redirect_valid}, 32'd1);
        check("t1_rpc",  redirect_pc, 32'h120);
        check("t1_mis",  {31'b0, misalign}, 32'd0);
        nop_beat();
        check("t1_k1_exv", {31'b0, ex_valid}, 32'd0);
        check("t1_k1_rv",  {31'b0, redirect_valid}, 32'd0);
        nop_beat();
        check("t1_k2_exv", {31'b0, ex_valid}, 32'd0);
        nop_beat();
        check("t1_live", {31'b0, ex_valid}, 32'd1);
        step();
        check("t1_br", br_cnt, 32'd1);
        check("t1_tk", taken_cnt, 32'd1);

        // 2: blt signed taken, bltu same operands not taken
        issue(mk(1'b1, 3'b011, 2'b10), 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8);
        check("t2_blt_rv",  {31'b0, redirect_valid}, 32'd1);
        check("t2_blt_rpc", redirect_pc, 32'h208);
        nop_beat();
        nop_beat();
        issue(mk(1'b1, 3'b101, 2'b10), 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8);
        check("t2_bltu_exv", {31'b0, ex_valid}, 32'd1);
        check("t2_bltu_rv",  {31'b0, redirect_valid}, 32'd0);
        step();
        check("t2_br", br_cnt, 32'd3);
        check("t2_tk", taken_cnt, 32'd2);

        // 3: register-relative jumps, bit 0 cleared, bit 1 flags misalign
        issue(mk(1'b1, 3'b000, 2'b00), 32'h500, 32'h1001, 32'h0, 32'd4);
        check("t3a_rv",  {31'b0, redirect_valid}, 32'd1);
        check("t3a_rpc", redirect_pc, 32'h1004);
        check("t3a_mis", {31'b0, misalign}, 32'd0);
        nop_beat();
        nop_beat();
        issue(mk(1'b1, 3'b000, 2'b00), 32'h500, 32'h1001, 32'h0, 32'd6);
        check("t3b_rv",  {31'b0, redirect_valid}, 32'd1);
        check("t3b_rpc", redirect_pc, 32'h1006);
        check("t3b_mis", {31'b0, misalign}, 32'd1);
        nop_beat();
        nop_beat();
        step();
        check("t3_br", br_cnt, 32'd5);
        check("t3_tk", taken_cnt, 32'd4);

        // 4: taken bge held by stall for 3 cycles; beats offered during stall are ignored
        issue(mk(1'b1, 3'b100, 2'b10), 32'h300, 32'd3, 32'd3, 32'h10);
        stall = 1'b1;
        check("t4_rpc", redirect_pc, 32'h310);
        pulses = 0;
        in_valid = 1'b1;
        in_sign  = mk(1'b0, 3'b000, 2'b00);
        for (int i = 0; i < 3; i++) begin
            if (redirect_valid) pulses++;
            step();
        end
        in_valid = 1'b0;
        check("t4_pulses", pulses, 32'd1);
        check("t4_hold_exv", {31'b0, ex_valid}, 32'd1);
        check("t4_br", br_cnt, 32'd6);
        check("t4_tk", taken_cnt, 32'd5);
        stall = 1'b0;
        nop_beat();
        check("t4_k1_exv", {31'b0, ex_valid}, 32'd0);
        nop_beat();
        check("t4_k2_exv", {31'b0, ex_valid}, 32'd0);
        nop_beat();
        check("t4_live", {31'b0, ex_valid}, 32'd1);

        // 5: reset in the middle of KILL with one beat still to drop
        issue(mk(1'b1, 3'b001, 2'b10), 32'h400, 32'd7, 32'd7, 32'h0);
        check("t5_rv", {31'b0, redirect_valid}, 32'd1);
        nop_beat();
        check("t5_k1_exv", {31'b0, ex_valid}, 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("t5_rst_exv",  {31'b0, ex_valid}, 32'd0);
        check("t5_rst_rv",   {31'b0, redirect_valid}, 32'd0);
        check("t5_rst_rpc",  redirect_pc, 32'd0);
        check("t5_rst_mis",  {31'b0, misalign}, 32'd0);
        check("t5_rst_br",   br_cnt, 32'd0);
        check("t5_rst_sign", {10'b0, ex_sign}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        nop_beat();
        check("t5_after_exv", {31'b0, ex_valid}, 32'd1);

        // 6: counter wrap from all-ones, then reserved op under npc_sel
        step();
        force dut.r_br_cnt    = 32'hFFFF_FFFF;
        force dut.r_taken_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_br_cnt;
        release dut.r_taken_cnt;
        check("t6_pre_br", br_cnt, 32'hFFFF_FFFF);
        issue(mk(1'b1, 3'b001, 2'b10), 32'h600, 32'd1, 32'd1, 32'h4);
        check("t6_rv", {31'b0, redirect_valid}, 32'd1);
        nop_beat();
        check("t6_wrap_br", br_cnt, 32'd0);
        check("t6_wrap_tk", taken_cnt, 32'd0);
        nop_beat();
        issue(mk(1'b1, 3'b111, 2'b10), 32'h700, 32'd0, 32'd0, 32'h0);
        check("t6_rsv_exv", {31'b0, ex_valid}, 32'd1);
        check("t6_rsv_rv",  {31'b0, redirect_valid}, 32'd0);
        step();
        check("t6_rsv_br", br_cnt, 32'd1);
        check("t6_rsv_tk", taken_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
